// File: rtl/tdc_interval_pkg.sv
// Shared definitions for the TDC interval block: tap/decoder widths, FSM state
// encodings and error-vector bit positions.
package tdc_interval_pkg;

  localparam int unsigned NUM_TAPS   = 64;
  localparam int unsigned NUM_DECODE = $clog2(NUM_TAPS);

  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_OVERRUN = 2;
  localparam int unsigned ERR_TIMEOUT = 1;
  localparam int unsigned ERR_NO_EDGE = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CALC = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/tdc_avg_acc.sv
// Running accumulator for averaged TDC results: sums 2^AVG_LOG2 values and
// presents the mean and OR-ed error flags combinationally with the last add.
module tdc_avg_acc
  import tdc_interval_pkg::*;
#(
  parameter int unsigned VAL_W    = 23,
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_add,
  input  logic [VAL_W-1:0] i_value,
  input  logic [ERR_W-1:0] i_err,
  output logic             o_last_c,
  output logic [VAL_W-1:0] o_avg_c,
  output logic [ERR_W-1:0] o_err_c
);

  localparam int unsigned ACC_W = VAL_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned LAST  = (1 << AVG_LOG2) - 1;

  logic [ACC_W-1:0] r_sum;
  logic [ERR_W-1:0] r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] w_sum;

  assign w_sum    = r_sum + ACC_W'(i_value);
  assign o_last_c = (r_cnt == CNT_W'(LAST));
  assign o_avg_c  = VAL_W'(w_sum >> AVG_LOG2);
  assign o_err_c  = r_err | i_err;

  // The final add of a block clears the accumulator for the next block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
      r_err <= '0;
      r_cnt <= '0;
    end else if (i_add) begin
      if (o_last_c) begin
        r_sum <= '0;
        r_err <= '0;
        r_cnt <= '0;
      end else begin
        r_sum <= w_sum;
        r_err <= o_err_c;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tdc_interval.sv
// TDC interval calculator: pairs start/stop decoder results into a tap-unit
// interval with valid/ready output. Define TDC_AVG_EN to average 2^AVG_LOG2 results.
module tdc_interval
  import tdc_interval_pkg::*;
#(
  parameter  int unsigned COARSE_W     = 16,
  parameter  int unsigned TAPS_PER_CLK = 36,
  parameter  int unsigned TIMEOUT      = 8,
  parameter  int unsigned AVG_LOG2     = 3,
  localparam int unsigned RES_W        = COARSE_W + NUM_DECODE + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_finished,
  input  logic [NUM_DECODE-1:0] start_bin,
  input  logic                  stop_finished,
  input  logic [NUM_DECODE-1:0] stop_bin,
  input  logic [COARSE_W-1:0]   coarse_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RES_W-1:0]      interval,
  output logic [ERR_W-1:0]      err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  if (TAPS_PER_CLK > NUM_TAPS || AVG_LOG2 > 16 || TIMEOUT == 0) begin : g_bad_param
    $error("tdc_interval: unsupported parameter combination");
  end

  state_t                r_state;
  logic [NUM_DECODE-1:0] r_start_bin;
  logic [NUM_DECODE-1:0] r_stop_bin;
  logic [COARSE_W-1:0]   r_coarse;
  logic                  r_have_start;
  logic                  r_have_stop;
  logic                  r_ovr_pend;
  logic [TMR_W-1:0]      r_timer;

  logic                  w_any_pulse;
  logic                  w_rep;
  logic                  w_complete;
  logic                  w_timeout;
  logic                  w_produce;
  logic                  w_no_edge;
  logic [RES_W-1:0]      w_sum;
  logic [RES_W-1:0]      w_calc;
  logic [RES_W-1:0]      w_res;
  logic [ERR_W-1:0]      w_res_err;
  logic                  w_out_go;
  logic [RES_W-1:0]      w_out_int;
  logic [ERR_W-1:0]      w_out_err;

  assign w_any_pulse = start_finished | stop_finished;
  assign w_rep       = (r_state == ST_WAIT) &&
                       ((start_finished && r_have_start) || (stop_finished && r_have_stop));
  assign w_complete  = (r_state == ST_WAIT) &&
                       (r_have_start || start_finished) && (r_have_stop || stop_finished);
  assign w_timeout   = (r_state == ST_WAIT) && !w_complete &&
                       (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_produce   = (r_state == ST_CALC) || w_timeout;

  // Unsigned interval with negative results clamped to zero.
  assign w_sum  = RES_W'(r_coarse) * RES_W'(TAPS_PER_CLK) + RES_W'(r_start_bin);
  assign w_calc = (w_sum < RES_W'(r_stop_bin)) ? '0 : (w_sum - RES_W'(r_stop_bin));
  assign w_res  = w_timeout ? '0 : w_calc;

  assign w_no_edge = (r_have_start && (r_start_bin == '0)) ||
                     (r_have_stop && (r_stop_bin == '0));

  always_comb begin
    w_res_err              = '0;
    w_res_err[ERR_OVERRUN] = r_ovr_pend | w_rep | ((r_state == ST_CALC) && w_any_pulse);
    w_res_err[ERR_TIMEOUT] = w_timeout;
    w_res_err[ERR_NO_EDGE] = w_no_edge;
  end

`ifdef TDC_AVG_EN
  tdc_avg_acc #(
    .VAL_W    (RES_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg_acc (
    .clk      (clk),
    .rst      (rst),
    .i_add    (w_produce),
    .i_value  (w_res),
    .i_err    (w_res_err),
    .o_last_c (w_out_go),
    .o_avg_c  (w_out_int),
    .o_err_c  (w_out_err)
  );
`else
  assign w_out_go  = 1'b1;
  assign w_out_int = w_res;
  assign w_out_err = w_res_err;
`endif

  // Control FSM; result production after the case overrides per-state updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_start_bin  <= '0;
      r_stop_bin   <= '0;
      r_coarse     <= '0;
      r_have_start <= 1'b0;
      r_have_stop  <= 1'b0;
      r_ovr_pend   <= 1'b0;
      r_timer      <= '0;
      out_valid    <= 1'b0;
      interval     <= '0;
      err          <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (start_finished) begin
            r_start_bin  <= start_bin;
            r_have_start <= 1'b1;
          end
          if (stop_finished) begin
            r_stop_bin  <= stop_bin;
            r_coarse    <= coarse_count;
            r_have_stop <= 1'b1;
          end
          if (start_finished && stop_finished) begin
            r_state <= ST_CALC;
          end else if (w_any_pulse) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (start_finished) begin
            r_start_bin  <= start_bin;
            r_have_start <= 1'b1;
          end
          if (stop_finished) begin
            r_stop_bin  <= stop_bin;
            r_coarse    <= coarse_count;
            r_have_stop <= 1'b1;
          end
          if (w_rep) begin
            r_ovr_pend <= 1'b1;
          end
          if (w_complete) begin
            r_state <= ST_CALC;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_CALC: begin
          r_state <= ST_CALC;
        end
        ST_HOLD: begin
          // Dropped pulses mark the held result, or the next one if it leaves now.
          if (w_any_pulse) begin
            if (out_ready) begin
              r_ovr_pend <= 1'b1;
            end else begin
              err[ERR_OVERRUN] <= 1'b1;
            end
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_produce) begin
        r_have_start <= 1'b0;
        r_have_stop  <= 1'b0;
        r_ovr_pend   <= 1'b0;
        r_timer      <= '0;
        if (w_out_go) begin
          interval  <= w_out_int;
          err       <= w_out_err;
          out_valid <= 1'b1;
          r_state   <= ST_HOLD;
        end else begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_interval.sv
// Directed scoreboard bench for tdc_interval; expected results come from a
// small reference model and are queued as each measurement is stimulated.
module tb_tdc_interval;
  import tdc_interval_pkg::*;

  localparam int unsigned COARSE_W = 16;
  localparam int unsigned TAPS     = 36;
  localparam int unsigned TMO      = 8;
  localparam int unsigned AVG_LOG2 = 3;
  localparam int unsigned RES_W    = COARSE_W + NUM_DECODE + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start_finished = 1'b0;
  logic [NUM_DECODE-1:0] start_bin = '0;
  logic                  stop_finished = 1'b0;
  logic [NUM_DECODE-1:0] stop_bin = '0;
  logic [COARSE_W-1:0]   coarse_count = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [RES_W-1:0]      interval;
  logic [ERR_W-1:0]      err;

  typedef struct packed {
    logic [RES_W-1:0] ival;
    logic [ERR_W-1:0] err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_xfer = 0;

  always #5 clk = ~clk;

  tdc_interval #(
    .COARSE_W     (COARSE_W),
    .TAPS_PER_CLK (TAPS),
    .TIMEOUT      (TMO),
    .AVG_LOG2     (AVG_LOG2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_finished (start_finished),
    .start_bin      (start_bin),
    .stop_finished  (stop_finished),
    .stop_bin       (stop_bin),
    .coarse_count   (coarse_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .interval       (interval),
    .err            (err)
  );

  always @(posedge clk) begin
    if (out_valid && out_ready) n_xfer++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int coarse, input int sbin, input int pbin,
                                 input logic ovr);
    exp_t m;
    int   v;
    v = coarse * int'(TAPS) + sbin - pbin;
    if (v < 0) v = 0;
    m.ival = RES_W'(v);
    m.err  = {ovr, 1'b0, (sbin == 0) || (pbin == 0)};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input int sbin, input int pbin,
                       input int coarse);
    start_finished = s;
    start_bin      = NUM_DECODE'(sbin);
    stop_finished  = p;
    stop_bin       = NUM_DECODE'(pbin);
    coarse_count   = COARSE_W'(coarse);
    tick();
    start_finished = 1'b0;
    stop_finished  = 1'b0;
  endtask

  // Counts negedges from the edge that sampled the final pulse until out_valid.
  task automatic wait_valid(input string tag, input int max_cyc, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_int"}, 32'(interval), 32'(e.ival));
      check({tag, "_err"}, 32'(err), 32'(e.err));
    end
  endtask

  task automatic accept(input string tag);
    int x0;
    x0 = n_xfer;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_vld0"}, 32'(out_valid), 0);
    check({tag, "_xfer"}, n_xfer - x0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(out_valid), 0);
    check("rst_int", 32'(interval), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b1;
    tick();

`ifdef TDC_AVG_EN
    // Eight results 100..107 average to 103 (sum 828 >> 3).
    for (int k = 0; k < 8; k++) begin
      if (k == 7) sb.push_back(exp_t'{ival: RES_W'(103), err: 3'b000});
      pulse(1'b1, 1'b1, 30 + k, 2, 2);
      if (k < 7) begin
        repeat (3) @(negedge clk);
        check("avg_no_vld", 32'(out_valid), 0);
        tick();
      end
    end
    wait_valid("avg", 10, 2);
    pop_check("avg");
    accept("avg");
`else
    // Start then stop two cycles later: 3*36+10-4 = 114.
    sb.push_back(model(3, 10, 4, 1'b0));
    pulse(1'b1, 1'b0, 10, 0, 0);
    tick();
    pulse(1'b0, 1'b1, 0, 4, 3);
    wait_valid("basic", 10, 2);
    pop_check("basic");
    accept("basic");

    // Simultaneous pulses with negative difference clamp to zero.
    sb.push_back(model(0, 5, 9, 1'b0));
    pulse(1'b1, 1'b1, 5, 9, 0);
    wait_valid("clamp", 10, 2);
    pop_check("clamp");
    accept("clamp");

    // Start only: 8 cycles in WAIT then HOLD, visible at the 9th negedge.
    sb.push_back(exp_t'{ival: '0, err: 3'b010});
    pulse(1'b1, 1'b0, 7, 0, 0);
    wait_valid("tmo", 20, int'(TMO) + 1);
    pop_check("tmo");
    accept("tmo");

    // Held result with back-pressure and a dropped start pulse in HOLD.
    sb.push_back(model(2, 20, 3, 1'b1));
    pulse(1'b1, 1'b1, 20, 3, 2);
    wait_valid("hold", 10, 2);
    check("hold_int0", 32'(interval), 89);
    for (int i = 0; i < 5; i++) begin
      tick();
      start_finished = (i == 1);
      start_bin      = NUM_DECODE'(33);
      @(negedge clk);
      check("hold_int", 32'(interval), 89);
      check("hold_vld", 32'(out_valid), 1);
    end
    pop_check("hold");
    accept("hold");
    repeat (12) @(negedge clk);
    check("hold_no_spurious", 32'(out_valid), 0);
    tick();

    // Repeated start in WAIT overwrites the bin: 36+40-5 = 71, overrun.
    sb.push_back(model(1, 40, 5, 1'b1));
    pulse(1'b1, 1'b0, 30, 0, 0);
    pulse(1'b1, 1'b0, 40, 0, 0);
    pulse(1'b0, 1'b1, 0, 5, 1);
    wait_valid("rep", 10, 2);
    pop_check("rep");
    accept("rep");

    // Zero start bin flags no_edge: 72+0-8 = 64.
    sb.push_back(model(2, 0, 8, 1'b0));
    pulse(1'b1, 1'b1, 0, 8, 2);
    wait_valid("noedge", 10, 2);
    pop_check("noedge");
    accept("noedge");

    // Asynchronous reset during HOLD, then a fresh measurement.
    pulse(1'b1, 1'b1, 12, 2, 0);
    wait_valid("prerst", 10, 2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_vld", 32'(out_valid), 0);
    check("arst_int", 32'(interval), 0);
    check("arst_err", 32'(err), 0);
    #1;
    rst = 1'b1;
    tick();
    sb.push_back(model(1, 1, 1, 1'b0));
    pulse(1'b1, 1'b1, 1, 1, 1);
    wait_valid("postrst", 10, 2);
    pop_check("postrst");
    accept("postrst");
`endif

    check("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_interval.md
TDC_INTERVAL -- requirements
Module: tdc_interval

Interface
REQ-001 SHALL have parameter COARSE_W, default 16: width of the coarse clock-cycle count.
REQ-002 SHALL have parameter TAPS_PER_CLK, default 36: fine taps spanned by one clk period.
REQ-003 SHALL have parameter TIMEOUT, default 8: maximum clk cycles between the first and second decoder finish pulse.
REQ-004 SHALL have parameter AVG_LOG2, default 3: log2 of the averaging depth, used only when averaging is compiled in.
REQ-005 clk  input  1  single clock, all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 start_finished  input  1  one-cycle pulse from the start-edge decoder.
REQ-008 start_bin  input  NUM_DECODE  start-edge tap index, valid while start_finished is high.
REQ-009 stop_finished  input  1  one-cycle pulse from the stop-edge decoder.
REQ-010 stop_bin  input  NUM_DECODE  stop-edge tap index, valid while stop_finished is high.
REQ-011 coarse_count  input  COARSE_W  whole clk periods between start and stop, sampled with stop_finished.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 interval  output  RES_W=COARSE_W+NUM_DECODE+1  interval in tap units.
REQ-015 err  output  3  {overrun, timeout, no_edge}, valid with out_valid.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, CALC, HOLD.
REQ-017 IDLE: on either finish pulse, capture that bin and go to WAIT; on both pulses in the same cycle, capture both and go to CALC.
REQ-018 WAIT: on the missing pulse, capture it and go to CALC; after TIMEOUT cycles without it, go to HOLD with timeout=1 and interval=0.
REQ-019 CALC (exactly 1 cycle): interval = coarse_count*TAPS_PER_CLK + start_bin - stop_bin, computed at RES_W bits, unsigned.
REQ-020 A negative result SHALL be clamped to 0; a captured bin equal to 0 SHALL set no_edge.
REQ-021 HOLD: out_valid=1; interval and err SHALL stay stable until out_ready=1, then return to IDLE.
REQ-022 Latency from the second finish pulse to out_valid SHALL be 2 cycles.
REQ-023 A finish pulse received in CALC or HOLD SHALL be dropped and SHALL set overrun on the current result if still in HOLD, otherwise on the next result.
REQ-024 out_valid and out_ready both high SHALL complete exactly one transfer.
REQ-025 A repeated pulse of an already-captured decoder in WAIT SHALL overwrite the captured bin and set overrun.

Reset
REQ-026 Assertion of rst SHALL immediately force IDLE, out_valid=0, interval=0, err=0, and clear all captures and counters, including mid-handshake.
REQ-027 Deassertion SHALL be used synchronously; the first accepted pulse is the one in the cycle after release.

Configuration
REQ-028 With TDC_AVG_EN defined: 2^AVG_LOG2 consecutive results SHALL be accumulated in COARSE_W+NUM_DECODE+1+AVG_LOG2 bits, and out_valid SHALL rise only after the last one, carrying sum>>AVG_LOG2 and the OR of all err bits.
REQ-029 Without TDC_AVG_EN: every measurement SHALL be output individually, with no accumulator logic present.

Structure
REQ-030 NUM_DECODE, NUM_TAPS, the FSM state encodings and the err bit positions SHALL live in the shared defines file.
REQ-031 The averaging accumulator SHALL be a sub-module named tdc_avg_acc, instantiated only under TDC_AVG_EN.

Verification
REQ-032 TAPS_PER_CLK=36, coarse=3, start_bin=10, stop_bin=4, pulses 2 cycles apart -> interval=114, err=000, out_valid 2 cycles after stop pulse.
REQ-033 Both pulses same cycle, coarse=0, start_bin=5, stop_bin=9 -> interval=0, err=000.
REQ-034 Start pulse only, TIMEOUT=8 -> out_valid after 8 cycles in WAIT, interval=0, err=010.
REQ-035 out_ready low for 5 cycles plus extra start pulse during HOLD -> interval held, overrun=1, single transfer when out_ready rises.
REQ-036 rst asserted during HOLD -> out_valid=0 asynchronously; next measurement coarse=1, start_bin=1, stop_bin=1 -> 36.
REQ-037 TDC_AVG_EN, AVG_LOG2=3, eight results 100..107 -> single output 103.
